norm_shift_ctrl: RTL and testbench
==================================

Name: norm_shift_ctrl

Overview:
- Sequential leading-one detector for the add/subtract datapath.
- Scans the significand produced by the adder and generates the shift amount, direction and fill bit that drive the normalization barrel shifter.
- Sits between the significand adder output and the barrel shifter's shift-control inputs.
- Scans CHUNK bits per cycle and uses a start/done handshake so the FSM can sequence the shifter load.

Parameters:
SWR, 26, significand width incl. implicit, guard and round bits (55 for double)
EW, 8, shift-value width (11 for double)
CHUNK, 4, bits examined per scan cycle; 1 <= CHUNK <= SWR

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
load_i  input  1  start strobe; accepted only when ready_o=1
Add_Subt_result_i  input  SWR  adder significand, sampled on accepted load_i
Add_overflow_i  input  1  adder carry-out, sampled on accepted load_i
ready_o  output  1  block idle, can accept load_i
done_o  output  1  one-cycle pulse, shift outputs valid
Shift_Value_o  output  EW  shift amount to barrel shifter
Left_Right_o  output  1  1=left shift (normalize), 0=right shift (overflow)
Bit_Shift_o  output  1  bit inserted into vacated positions
Zero_flag_o  output  1  result significand all zeros

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE, ready_o=1.
  - done_o, Shift_Value_o, Left_Right_o, Bit_Shift_o and Zero_flag_o all 0.
  - Scan register and counter cleared. Applies equally mid-scan.
- FSM states: IDLE, SCAN, DONE.
- IDLE (ready_o=1):
  - On load_i=1 at cycle 0, capture Add_Subt_result_i into the working register (low side zero-padded to N*CHUNK bits, N=ceil(SWR/CHUNK)), capture overflow, clear the counter, deassert ready_o.
  - If overflow=1, go to DONE. Otherwise go to SCAN.
- SCAN: each cycle examine the top CHUNK bits of the working register.
  - Any bit is 1: counter += index of first 1 from MSB within the chunk; go to DONE.
  - Otherwise: counter += CHUNK, working register shifts left by CHUNK. If this was chunk N-1, the result is zero; go to DONE with the zero indication.
- DONE: for one cycle, done_o=1; then return to IDLE with ready_o=1.
  - Shift_Value_o, Left_Right_o, Bit_Shift_o and Zero_flag_o update on entry to DONE and hold until the next DONE or reset.
- Output values at DONE:
  - Overflow: Shift_Value_o=1, Left_Right_o=0, Bit_Shift_o=1, Zero_flag_o=0.
  - Normal: Shift_Value_o=leading-zero count, Left_Right_o=1, Bit_Shift_o=0, Zero_flag_o=0.
  - Zero: Shift_Value_o=0, Left_Right_o=1, Bit_Shift_o=0, Zero_flag_o=1.
- Latency (load at cycle 0):
  - Overflow: done_o at cycle 1.
  - First 1 in chunk k (k=floor(lz/CHUNK)): done_o at cycle k+2.
  - Zero result: done_o at cycle N+1.
- Width rules:
  - Counter width is EW.
  - Leading-zero count is always <= SWR-1, because padding bits are 0.
  - Requires SWR <= 2^EW - 1.
- load_i while ready_o=0 is ignored; no queueing.
- Add_Subt_result_i and Add_overflow_i are don't-care outside the accepted load cycle.
- Overflow takes priority over the data contents.

Optional Feature:
- Macro NORM_SHIFT_CLAMP_EN.
- Defined:
  - Adds input Max_Shift_i [EW-1:0], sampled with load_i, and output Clamp_o (reset 0).
  - For normal (left) results, Shift_Value_o = min(lz, Max_Shift_i).
  - Clamp_o=1 when lz > Max_Shift_i (subnormal result), else 0.
  - Overflow and zero cases force Clamp_o=0.
  - Latency is unchanged.
- Undefined:
  - Neither port exists.
  - Shift_Value_o is always the unclamped count.

Test Plan:
1. SWR=26, CHUNK=4; load with data 26'h0400000 (bit 22), overflow=0 -> done_o at cycle 2, Shift_Value_o=3, Left_Right_o=1, Bit_Shift_o=0, Zero_flag_o=0.
2. Data 26'h0000001 -> done_o at cycle 8 (chunk 6), Shift_Value_o=25, Left_Right_o=1. Data 26'h2000000 -> done_o at cycle 2, Shift_Value_o=0.
3. Data 0, overflow=0 -> done_o at cycle 8, Zero_flag_o=1, Shift_Value_o=0.
4. Data 26'h3FFFFFF, overflow=1 -> done_o at cycle 1, Shift_Value_o=1, Left_Right_o=0, Bit_Shift_o=1. Also: a second load_i asserted during SCAN is ignored; ready_o returns to 1 the cycle after done_o.
5. Start a load with data 26'h0000010, assert rst=0 at cycle 3 -> all outputs 0 immediately, ready_o=1. After release, a new load with 26'h0800000 -> Shift_Value_o=2 at cycle 2.
6. With NORM_SHIFT_CLAMP_EN: data 26'h0000100 (lz=17), Max_Shift_i=10 -> Shift_Value_o=10, Clamp_o=1. Same data with Max_Shift_i=20 -> Shift_Value_o=17, Clamp_o=0.

Source files
------------

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: sequential leading-one detector driving the
// normalization barrel shifter. Scans CHUNK bits per cycle from the MSB.
// Optional clamp feature: define NORM_SHIFT_CLAMP_EN to add Max_Shift_i
// and Clamp_o (shift limited to Max_Shift_i for left results).
module norm_shift_ctrl #(
   parameter int SWR   = 26,
   parameter int EW    = 8,
   parameter int CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic [SWR-1:0] Add_Subt_result_i,
   input  logic           Add_overflow_i,
`ifdef NORM_SHIFT_CLAMP_EN
   input  logic [EW-1:0]  Max_Shift_i,
   output logic           Clamp_o,
`endif
   output logic           ready_o,
   output logic           done_o,
   output logic [EW-1:0]  Shift_Value_o,
   output logic           Left_Right_o,
   output logic           Bit_Shift_o,
   output logic           Zero_flag_o
);

   localparam int N   = (SWR + CHUNK - 1) / CHUNK;
   localparam int PW  = N * CHUNK;
   localparam int PAD = PW - SWR;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    wreg;
   logic [EW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] top;
   logic             hit;
   logic             last;
   logic [EW-1:0]    pos;
   logic [EW-1:0]    lz;
   logic [EW-1:0]    sv_norm;
`ifdef NORM_SHIFT_CLAMP_EN
   logic [EW-1:0]    max_q;
   logic             clamp_norm;
`endif

   assign ready_o = (state == IDLE);
   assign done_o  = (state == DONE);

   // Chunk examination: first-one position counted from the chunk MSB.
   always_comb begin
      top  = wreg[PW-1 -: CHUNK];
      hit  = |top;
      last = (idx == IW'(N - 1));
      pos  = '0;
      // Ascending loop: highest set bit is assigned last and wins.
      for (int i = 0; i < CHUNK; i++)
         if (top[i]) pos = EW'(CHUNK - 1 - i);
      lz = cnt + pos;
`ifdef NORM_SHIFT_CLAMP_EN
      clamp_norm = (lz > max_q);
      sv_norm    = clamp_norm ? max_q : lz;
`else
      sv_norm    = lz;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; overflow bypasses the scan entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_i) state_nxt = Add_overflow_i ? DONE : SCAN;
         SCAN:    if (hit || last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: scan register, counter and the held shift-control outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wreg          <= '0;
         cnt           <= '0;
         idx           <= '0;
         Shift_Value_o <= '0;
         Left_Right_o  <= 1'b0;
         Bit_Shift_o   <= 1'b0;
         Zero_flag_o   <= 1'b0;
`ifdef NORM_SHIFT_CLAMP_EN
         max_q         <= '0;
         Clamp_o       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (load_i) begin
               // Low side zero-padded so padding never produces a hit.
               wreg <= PW'(Add_Subt_result_i) << PAD;
               cnt  <= '0;
               idx  <= '0;
`ifdef NORM_SHIFT_CLAMP_EN
               max_q <= Max_Shift_i;
`endif
               if (Add_overflow_i) begin
                  Shift_Value_o <= EW'(1);
                  Left_Right_o  <= 1'b0;
                  Bit_Shift_o   <= 1'b1;
                  Zero_flag_o   <= 1'b0;
`ifdef NORM_SHIFT_CLAMP_EN
                  Clamp_o       <= 1'b0;
`endif
               end
            end
            SCAN: begin
               if (hit) begin
                  Shift_Value_o <= sv_norm;
                  Left_Right_o  <= 1'b1;
                  Bit_Shift_o   <= 1'b0;
                  Zero_flag_o   <= 1'b0;
`ifdef NORM_SHIFT_CLAMP_EN
                  Clamp_o       <= clamp_norm;
`endif
               end else begin
                  cnt  <= cnt + EW'(CHUNK);
                  wreg <= wreg << CHUNK;
                  idx  <= idx + 1'b1;
                  if (last) begin
                     Shift_Value_o <= '0;
                     Left_Right_o  <= 1'b1;
                     Bit_Shift_o   <= 1'b0;
                     Zero_flag_o   <= 1'b1;
`ifdef NORM_SHIFT_CLAMP_EN
                     Clamp_o       <= 1'b0;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Bench for norm_shift_ctrl: latency/value model plus directed literals.
module tb_norm_shift_ctrl;

   localparam int SWR   = 26;
   localparam int EW    = 8;
   localparam int CHUNK = 4;
   localparam int N     = (SWR + CHUNK - 1) / CHUNK;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           load_i = 1'b0;
   logic [SWR-1:0] din = '0;
   logic           ovf_i = 1'b0;
   logic [EW-1:0]  max_i = '1;
   logic           ready_o, done_o, lr_o, bs_o, zf_o;
   logic [EW-1:0]  sv_o;
`ifdef NORM_SHIFT_CLAMP_EN
   logic           cl_o;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   norm_shift_ctrl #(.SWR(SWR), .EW(EW), .CHUNK(CHUNK)) dut (
      .clk               (clk),
      .rst               (rst),
      .load_i            (load_i),
      .Add_Subt_result_i (din),
      .Add_overflow_i    (ovf_i),
`ifdef NORM_SHIFT_CLAMP_EN
      .Max_Shift_i       (max_i),
      .Clamp_o           (cl_o),
`endif
      .ready_o           (ready_o),
      .done_o            (done_o),
      .Shift_Value_o     (sv_o),
      .Left_Right_o      (lr_o),
      .Bit_Shift_o       (bs_o),
      .Zero_flag_o       (zf_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: leading-zero count by plain search, latency from chunk index.
   task automatic model_of(input logic [SWR-1:0] d, input logic ov, input logic [EW-1:0] mx,
                           output int lat, output logic [EW-1:0] sv,
                           output logic lr, output logic bs, output logic zf, output logic cl);
      int lz;
      lz = SWR;
      for (int i = 0; i < SWR; i++) if (d[i]) lz = SWR - 1 - i;
      cl = 1'b0;
      if (ov) begin
         lat = 1; sv = 1; lr = 0; bs = 1; zf = 0;
      end else if (d == '0) begin
         lat = N + 1; sv = 0; lr = 1; bs = 0; zf = 1;
      end else begin
         lat = lz / CHUNK + 2; sv = EW'(lz); lr = 1; bs = 0; zf = 0;
`ifdef NORM_SHIFT_CLAMP_EN
         if (lz > int'(mx)) begin sv = mx; cl = 1; end
`else
         if (mx == '0) cl = 1'b0;
`endif
      end
   endtask

   // Model state: 0 idle, 1 busy, 2 done-pulse cycle.
   int            m_mode = 0;
   int            m_left = 0;
   int            p_lat;
   logic [EW-1:0] p_sv, e_sv = '0;
   logic          p_lr, p_bs, p_zf, p_cl;
   logic          e_lr = 0, e_bs = 0, e_zf = 0, e_cl = 0;

   always @(posedge clk) begin
      if (!rst) begin
         m_mode = 0; m_left = 0;
         e_sv = '0; e_lr = 0; e_bs = 0; e_zf = 0; e_cl = 0;
      end else begin
         case (m_mode)
            0: if (load_i) begin
               model_of(din, ovf_i, max_i, p_lat, p_sv, p_lr, p_bs, p_zf, p_cl);
               m_left = p_lat - 1;
               m_mode = 1;
            end
            1: m_left--;
            default: m_mode = 0;
         endcase
         if (m_mode == 1 && m_left == 0) begin
            m_mode = 2;
            e_sv = p_sv; e_lr = p_lr; e_bs = p_bs; e_zf = p_zf; e_cl = p_cl;
         end
      end
   end

   // Compare every cycle against the model (or reset values during reset).
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_ready", ready_o, 1);
         chk("rst_done", done_o, 0);
         chk("rst_sv", sv_o, 0);
         chk("rst_lr", lr_o, 0);
         chk("rst_bs", bs_o, 0);
         chk("rst_zf", zf_o, 0);
      end else begin
         chk("ready", ready_o, 32'(m_mode == 0));
         chk("done", done_o, 32'(m_mode == 2));
         chk("shift_value", sv_o, e_sv);
         chk("left_right", lr_o, e_lr);
         chk("bit_shift", bs_o, e_bs);
         chk("zero_flag", zf_o, e_zf);
`ifdef NORM_SHIFT_CLAMP_EN
         chk("clamp", cl_o, e_cl);
`endif
      end
   end

   task automatic wait_ready();
      int t;
      t = 0;
      @(negedge clk);
      while (!ready_o && t < 50) begin @(negedge clk); t++; end
      chk("ready_wait", ready_o, 1);
   endtask

   // Directed transaction with hand-computed literal expectations.
   task automatic run_dir(input logic [SWR-1:0] d, input logic ov, input logic [EW-1:0] mx,
                          input bit extra, input int e_cyc, input int x_sv,
                          input logic x_lr, input logic x_bs, input logic x_zf, input logic x_cl);
      int got;
      wait_ready();
      @(posedge clk); #1;
      load_i = 1; din = d; ovf_i = ov; max_i = mx;
      got = -1;
      for (int c = 1; c <= 40 && got < 0; c++) begin
         @(posedge clk); #1;
         load_i = extra && (c == 3);
         din = extra && (c == 3) ? 26'h2000000 : SWR'($urandom);
         ovf_i = 0;
         @(negedge clk);
         if (done_o) got = c;
      end
      chk("done_cycle", got, e_cyc);
      chk("lit_sv", sv_o, x_sv);
      chk("lit_lr", lr_o, x_lr);
      chk("lit_bs", bs_o, x_bs);
      chk("lit_zf", zf_o, x_zf);
`ifdef NORM_SHIFT_CLAMP_EN
      chk("lit_cl", cl_o, x_cl);
`else
      if (x_cl) chk("lit_cl_unused", 0, 0);
`endif
      @(negedge clk);
      chk("ready_after_done", ready_o, 1);
      chk("done_pulse_len", done_o, 0);
   endtask

   initial begin
      int r;
      repeat (3) @(posedge clk);
      #1 rst = 1;

      run_dir(26'h0400000, 0, '1, 0, 2, 3, 1, 0, 0, 0);
      run_dir(26'h0000001, 0, '1, 1, 8, 25, 1, 0, 0, 0);
      run_dir(26'h2000000, 0, '1, 0, 2, 0, 1, 0, 0, 0);
      run_dir(26'h0000000, 0, '1, 0, 8, 0, 1, 0, 1, 0);
      run_dir(26'h3FFFFFF, 1, '1, 0, 1, 1, 0, 1, 0, 0);

      // Reset mid-scan.
      wait_ready();
      @(posedge clk); #1;
      load_i = 1; din = 26'h0000010; ovf_i = 0;
      @(posedge clk); #1 load_i = 0;
      @(posedge clk);
      @(posedge clk); #1 rst = 0;
      #1;
      chk("midrst_sv", sv_o, 0);
      chk("midrst_lr", lr_o, 0);
      chk("midrst_bs", bs_o, 0);
      chk("midrst_ready", ready_o, 1);
      @(posedge clk);
      @(posedge clk); #1 rst = 1;
      run_dir(26'h0800000, 0, '1, 0, 2, 2, 1, 0, 0, 0);

`ifdef NORM_SHIFT_CLAMP_EN
      run_dir(26'h0000100, 0, 8'd10, 0, 6, 10, 1, 0, 0, 1);
      run_dir(26'h0000100, 0, 8'd20, 0, 6, 17, 1, 0, 0, 0);
`endif

      // Random loads, including loads while busy (must be ignored).
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         r = int'($urandom);
         load_i = r[0] | r[1];
         if (r[4:2] == 0) din = '0;
         else din = SWR'($urandom) >> ($urandom % (SWR + 1));
         ovf_i = ($urandom % 6 == 0);
         max_i = EW'($urandom % 30);
      end
      #0 load_i = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
